// File: rtl/ps2_poly_voice_alloc.sv
`default_nettype none
// ============================================================================
// Module   : ps2_poly_voice_alloc
// Purpose  : PS/2 set-2 byte parser feeding a polyphonic voice allocator
//            that provides per-voice gate, key code and a linear release ramp.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_poly_voice_alloc #(
    parameter int NUM_VOICES  = 4,
    parameter int AMP_W       = 32,
    parameter int AMP_ON      = 5000000,
    parameter int DECAY_STEP  = 50000,
    parameter int RELEASE_DIV = 50000,
    parameter int STEAL       = 1
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
    input  logic [7:0]                  keyboard_data,
    input  logic                        data_received_en,
    output logic [NUM_VOICES-1:0]       voice_active,
    output logic [9*NUM_VOICES-1:0]     voice_code,
    output logic [AMP_W*NUM_VOICES-1:0] amplitude,
    output logic                        note_drop
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int PRE_W = (RELEASE_DIV > 1) ? $clog2(RELEASE_DIV) : 1;
    localparam logic [IDX_W-1:0] c_age_max = IDX_W'(NUM_VOICES - 1);
    localparam logic [PRE_W-1:0] c_pre_max = PRE_W'(RELEASE_DIV - 1);
    localparam logic [AMP_W-1:0] c_amp_on  = AMP_W'(AMP_ON);
    localparam logic [AMP_W-1:0] c_decay   = AMP_W'(DECAY_STEP);

    typedef enum logic [1:0] {
        P_IDLE    = 2'd0,
        P_EXT     = 2'd1,
        P_BRK     = 2'd2,
        P_EXT_BRK = 2'd3
    } parse_state_t;

    parse_state_t            r_state, w_state_nx;
    logic                    w_make, w_brk, w_ignore;
    logic [8:0]              w_ev_code;

    logic [NUM_VOICES-1:0]   r_active;
    logic [8:0]              r_code [NUM_VOICES];
    logic [AMP_W-1:0]        r_amp  [NUM_VOICES];
    logic [IDX_W-1:0]        r_age  [NUM_VOICES];
    logic [PRE_W-1:0]        r_pre;
    logic                    r_drop;

    logic                    w_hit, w_free_found, w_rel_found, w_old_found, w_tgt_found;
    logic [IDX_W-1:0]        w_free_idx, w_rel_idx, w_old_idx, w_old_age, w_tgt_idx;
    logic                    w_do_make, w_drop, w_tick;

    assign w_ignore = (keyboard_data == 8'h00) || (keyboard_data == 8'hAA) ||
                      (keyboard_data == 8'hEE) || (keyboard_data == 8'hFA) ||
                      (keyboard_data == 8'hFE) || (keyboard_data == 8'hFF);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) r_state <= P_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_make     = 1'b0;
        w_brk      = 1'b0;
        w_ev_code  = {1'b0, keyboard_data};
        if (data_received_en) begin
            case (r_state)
                P_IDLE: begin
                    if (keyboard_data == 8'hE0)      w_state_nx = P_EXT;
                    else if (keyboard_data == 8'hF0) w_state_nx = P_BRK;
                    else if (!w_ignore)              w_make     = 1'b1;
                end
                P_EXT: begin
                    if (keyboard_data == 8'hF0) begin
                        w_state_nx = P_EXT_BRK;
                    end else begin
                        w_make     = 1'b1;
                        w_ev_code  = {1'b1, keyboard_data};
                        w_state_nx = P_IDLE;
                    end
                end
                P_BRK: begin
                    w_brk      = 1'b1;
                    w_state_nx = P_IDLE;
                end
                default: begin
                    w_brk      = 1'b1;
                    w_ev_code  = {1'b1, keyboard_data};
                    w_state_nx = P_IDLE;
                end
            endcase
        end
    end

    // Descending scan so the lowest-index candidate is the one kept.
    always_comb begin
        w_hit        = 1'b0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_rel_found  = 1'b0;
        w_rel_idx    = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (r_active[i] && (r_code[i] == w_ev_code)) w_hit = 1'b1;
            if (!r_active[i] && (r_amp[i] == '0)) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
            if (!r_active[i]) begin
                w_rel_found = 1'b1;
                w_rel_idx   = IDX_W'(i);
            end
        end
    end

    // Ascending scan with strict compare: equal ages resolve to the lowest index.
    always_comb begin
        w_old_found = 1'b0;
        w_old_idx   = '0;
        w_old_age   = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (r_active[i] && (!w_old_found || (r_age[i] > w_old_age))) begin
                w_old_found = 1'b1;
                w_old_idx   = IDX_W'(i);
                w_old_age   = r_age[i];
            end
        end
    end

    always_comb begin
        w_tgt_found = 1'b1;
        w_tgt_idx   = w_free_idx;
        if (!w_free_found) begin
            if (w_rel_found)                     w_tgt_idx = w_rel_idx;
            else if ((STEAL != 0) && w_old_found) w_tgt_idx = w_old_idx;
            else                                 w_tgt_found = 1'b0;
        end
    end

    assign w_do_make = w_make && !w_hit && w_tgt_found;
    assign w_drop    = w_make && !w_hit && !w_tgt_found;
    assign w_tick    = (r_pre == c_pre_max);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_pre    <= '0;
            r_drop   <= 1'b0;
            r_active <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_code[i] <= '0;
                r_amp[i]  <= '0;
                r_age[i]  <= '0;
            end
        end else begin
            r_pre  <= w_tick ? '0 : r_pre + 1'b1;
            r_drop <= w_drop;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (w_tick && !r_active[i])
                    r_amp[i] <= (r_amp[i] > c_decay) ? r_amp[i] - c_decay : '0;
                if (w_do_make && (w_tgt_idx == IDX_W'(i))) begin
                    r_active[i] <= 1'b1;
                    r_code[i]   <= w_ev_code;
                    r_amp[i]    <= c_amp_on;
                    r_age[i]    <= '0;
                end else if (w_do_make && r_active[i] && (r_age[i] != c_age_max)) begin
                    r_age[i] <= r_age[i] + 1'b1;
                end
                if (w_brk && r_active[i] && (r_code[i] == w_ev_code))
                    r_active[i] <= 1'b0;
            end
        end
    end

    assign voice_active = r_active;
    assign note_drop    = r_drop;

    generate
        for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
            assign voice_code[9*g +: 9]        = r_code[g];
            assign amplitude[AMP_W*g +: AMP_W] = r_amp[g];
        end
    endgenerate

endmodule
`default_nettype wire
